// File: rtl/harp_pkg.sv
// rtl/harp_pkg.sv - shared widths, FSM states, event record and scan helpers for the harp voice scheduler
package harp_pkg;
  localparam int NUM_STRINGS = 8;
  localparam int NUM_VOICES  = 4;
  localparam int SW = $clog2(NUM_STRINGS);
  localparam int VW = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, FLUSH = 2'd2} state_e;

  typedef struct packed {
    logic          note_on;
    logic [SW-1:0] str;
    logic [VW-1:0] voice;
  } event_t;

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
  } spick_t;

  typedef struct packed {
    logic          found;
    logic [VW-1:0] idx;
  } vpick_t;

  // First set flag scanning upward from start with wrap; the downward loop leaves the nearest hit last.
  function automatic spick_t pick_rr(input logic [NUM_STRINGS-1:0] flags, input logic [SW-1:0] start);
    spick_t        res;
    logic [SW-1:0] idx;
    res = '0;
    for (int k = NUM_STRINGS - 1; k >= 0; k--) begin
      idx = start + SW'(k);
      if (flags[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  function automatic vpick_t lowest_set(input logic [NUM_VOICES-1:0] bits);
    vpick_t res;
    res = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (bits[k]) begin
        res.found = 1'b1;
        res.idx   = VW'(k);
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/beam_debouncer.sv
// rtl/beam_debouncer.sv - two-flop synchroniser plus stable-level debouncer for one beam
module beam_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic rise_o,
  output logic fall_o
);
  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/harp_voice_scheduler.sv
// rtl/harp_voice_scheduler.sv - debounced beam breaks to voice-allocated note-on/off events over valid/ready
module harp_voice_scheduler
  import harp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_STRINGS-1:0] beam_in,
  input  logic                   enable,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic                   evt_note_on,
  output logic [SW-1:0]          evt_string,
  output logic [VW-1:0]          evt_voice,
  output logic [NUM_VOICES-1:0]  voice_busy,
  output logic [7:0]             drop_count
);
  logic [NUM_STRINGS-1:0] rise, fall;

  for (genvar g = 0; g < NUM_STRINGS; g++) begin : g_beam
    beam_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clk_i (clk_clk),
      .rst_ni(reset_reset_n),
      .raw_i (beam_in[g]),
      .rise_o(rise[g]),
      .fall_o(fall[g])
    );
  end

  state_e                           state_q, state_d;
  logic [SW-1:0]                    rr_q, rr_d;
  logic [NUM_STRINGS-1:0]           press_q, press_d, rel_q, rel_d, held_q, held_d;
  logic [NUM_STRINGS-1:0][VW-1:0]   voice_of_q, voice_of_d;
  logic [NUM_VOICES-1:0]            busy_q, busy_d;
  logic [7:0]                       drop_q, drop_d;
  event_t                           evt_q, evt_d;
  logic                             valid_q, valid_d;

  spick_t        rsel, psel;
  vpick_t        vfree, vbusy;
  logic [SW-1:0] owner;
  logic          hs, svc;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    press_d    = press_q;
    rel_d      = rel_q;
    held_d     = held_q;
    voice_of_d = voice_of_q;
    busy_d     = busy_q;
    drop_d     = drop_q;
    evt_d      = evt_q;
    valid_d    = valid_q;
    svc        = 1'b0;
    rsel       = pick_rr(rel_q, rr_q);
    psel       = pick_rr(press_q, rr_q);
    vfree      = lowest_set(~busy_q);
    vbusy      = lowest_set(busy_q);
    owner      = '0;
    for (int i = 0; i < NUM_STRINGS; i++) begin
      if (held_q[i] && voice_of_q[i] == vbusy.idx) owner = SW'(i);
    end
    hs = valid_q & evt_ready;

    case (state_q)
      IDLE: begin
        if (!enable) begin
          state_d = FLUSH;
        end else if (rsel.found) begin
          if (held_q[rsel.idx]) begin
            evt_d.note_on = 1'b0;
            evt_d.str     = rsel.idx;
            evt_d.voice   = voice_of_q[rsel.idx];
            valid_d       = 1'b1;
            state_d       = EMIT;
          end else begin
            rel_d[rsel.idx] = 1'b0;
          end
        end else if (psel.found) begin
          if (vfree.found) begin
            evt_d.note_on = 1'b1;
            evt_d.str     = psel.idx;
            evt_d.voice   = vfree.idx;
            valid_d       = 1'b1;
            state_d       = EMIT;
          end else begin
            press_d[psel.idx] = 1'b0;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          end
        end
      end
      EMIT: begin
        if (hs) begin
          valid_d = 1'b0;
          rr_d    = evt_q.str + 1'b1;
          if (evt_q.note_on) begin
            busy_d[evt_q.voice]   = 1'b1;
            held_d[evt_q.str]     = 1'b1;
            voice_of_d[evt_q.str] = evt_q.voice;
            press_d[evt_q.str]    = 1'b0;
          end else begin
            busy_d[evt_q.voice] = 1'b0;
            held_d[evt_q.str]   = 1'b0;
            rel_d[evt_q.str]    = 1'b0;
          end
          state_d = enable ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        if (valid_q) begin
          if (hs) begin
            valid_d             = 1'b0;
            busy_d[evt_q.voice] = 1'b0;
            held_d[evt_q.str]   = 1'b0;
          end
        end else if (vbusy.found) begin
          evt_d.note_on = 1'b0;
          evt_d.str     = owner;
          evt_d.voice   = vbusy.idx;
          valid_d       = 1'b1;
        end else begin
          press_d = '0;
          rel_d   = '0;
          held_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flag already committed to an outstanding event counts as consumed, so a new edge queues behind it.
    if (enable) begin
      for (int i = 0; i < NUM_STRINGS; i++) begin
        svc = valid_d && (state_d == EMIT) && (evt_d.str == SW'(i));
        if (fall[i]) begin
          if (rel_d[i] && !(svc && !evt_d.note_on)) rel_d[i] = 1'b0;
          else press_d[i] = 1'b1;
        end
        if (rise[i]) begin
          if (press_d[i] && !(svc && evt_d.note_on)) begin
            press_d[i] = 1'b0;
            rel_d[i]   = 1'b0;
          end else begin
            rel_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      held_q     <= '0;
      voice_of_q <= '0;
      busy_q     <= '0;
      drop_q     <= '0;
      evt_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      held_q     <= held_d;
      voice_of_q <= voice_of_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      evt_q      <= evt_d;
      valid_q    <= valid_d;
    end
  end

  assign evt_valid   = valid_q;
  assign evt_note_on = evt_q.note_on;
  assign evt_string  = evt_q.str;
  assign evt_voice   = evt_q.voice;
  assign voice_busy  = busy_q;
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_harp_voice_scheduler.sv
// tb/tb_harp_voice_scheduler.sv - directed and randomized bench against an event-level reference model
module tb_harp_voice_scheduler;
  localparam int D   = 16;
  localparam int WIN = D + 140;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] beam = 8'hFF;
  logic       enable = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_note_on;
  logic [2:0] evt_string;
  logic [1:0] evt_voice;
  logic [3:0] voice_busy;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  harp_voice_scheduler #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk_clk      (clk),
    .reset_reset_n(reset_n),
    .beam_in      (beam),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_note_on  (evt_note_on),
    .evt_string   (evt_string),
    .evt_voice    (evt_voice),
    .voice_busy   (voice_busy),
    .drop_count   (drop_count)
  );

  int errors = 0;
  int checks = 0;
  logic rnd_ready = 1'b0;
  logic ready_fix = 1'b1;
  logic [5:0] obs_q[$];
  logic [5:0] exp_q[$];

  logic [7:0] stable_m;
  logic [7:0] held_m;
  int         vo_m [8];
  logic [3:0] busy_m;
  int         drop_m;
  int         rr_m;
  logic       en_m;

  initial forever begin
    @(posedge clk);
    #2;
    evt_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  initial forever begin
    @(negedge clk);
    if (reset_n && evt_valid && evt_ready) obs_q.push_back({evt_note_on, evt_string, evt_voice});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    stable_m = 8'hFF;
    held_m   = '0;
    busy_m   = '0;
    drop_m   = 0;
    rr_m     = 0;
    for (int i = 0; i < 8; i++) vo_m[i] = 0;
  endtask

  function automatic int first_rr(input logic [7:0] flags);
    for (int k = 0; k < 8; k++) if (flags[(rr_m + k) % 8]) return (rr_m + k) % 8;
    return 0;
  endfunction

  task automatic model_change(input logic [7:0] nb);
    logic [7:0] prs, rel;
    int i, v;
    prs = stable_m & ~nb;
    rel = ~stable_m & nb;
    stable_m = nb;
    if (!en_m) return;
    while (prs != 0 || rel != 0) begin
      if (rel != 0) begin
        i = first_rr(rel);
        rel[i] = 1'b0;
        if (held_m[i]) begin
          exp_q.push_back({1'b0, 3'(i), 2'(vo_m[i])});
          busy_m[vo_m[i]] = 1'b0;
          held_m[i] = 1'b0;
          rr_m = (i + 1) % 8;
        end
      end else begin
        i = first_rr(prs);
        prs[i] = 1'b0;
        v = -1;
        for (int k = 3; k >= 0; k--) if (!busy_m[k]) v = k;
        if (v >= 0) begin
          exp_q.push_back({1'b1, 3'(i), 2'(v)});
          busy_m[v] = 1'b1;
          held_m[i] = 1'b1;
          vo_m[i] = v;
          rr_m = (i + 1) % 8;
        end else if (drop_m < 255) begin
          drop_m++;
        end
      end
    end
  endtask

  task automatic model_flush();
    for (int v = 0; v < 4; v++) begin
      if (busy_m[v]) begin
        for (int i = 0; i < 8; i++) begin
          if (held_m[i] && vo_m[i] == v) begin
            exp_q.push_back({1'b0, 3'(i), 2'(v)});
            held_m[i] = 1'b0;
          end
        end
        busy_m[v] = 1'b0;
      end
    end
    held_m = '0;
  endtask

  task automatic settle(input string tag);
    int n;
    repeat (WIN) @(posedge clk);
    @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk({tag, "_evt"}, obs_q[k], exp_q[k]);
    chk({tag, "_busy"}, voice_busy, busy_m);
    chk({tag, "_drop"}, drop_count, drop_m);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic apply(input logic [7:0] nb, input string tag);
    @(negedge clk);
    beam = nb;
    model_change(nb);
    settle(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!evt_valid && n < D + 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, evt_valid, 1'b1);
  endtask

  initial begin
    logic [5:0] f;
    logic       steady;
    en_m = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", evt_valid, 1'b0);
    chk("reset_busy", voice_busy, 4'h0);
    chk("reset_drop", drop_count, 8'h0);

    // single press: latency from raw change to evt_valid, then release
    @(negedge clk);
    beam = 8'hF7;
    model_change(8'hF7);
    repeat (D + 3) @(posedge clk);
    @(negedge clk);
    chk("lat_before", evt_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", evt_valid, 1'b1);
    settle("press3");
    apply(8'hFF, "release3");

    // glitches shorter than the debounce window
    repeat (4) begin
      @(negedge clk);
      beam[5] = 1'b0;
      repeat (D / 2) @(negedge clk);
      beam[5] = 1'b1;
      repeat (D / 2) @(negedge clk);
    end
    settle("glitch");

    // five-string chord with four voices, then release the dropped string alone
    do_reset();
    apply(8'hE0, "chord");
    apply(8'hF0, "rel_dropped");
    apply(8'hFF, "chord_rel");

    // back-pressure: event must hold steady while ready is low
    ready_fix = 1'b0;
    @(negedge clk);
    beam = 8'h7F;
    model_change(8'h7F);
    wait_valid("stall_valid");
    f = {evt_note_on, evt_string, evt_voice};
    steady = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!evt_valid || {evt_note_on, evt_string, evt_voice} !== f) steady = 1'b0;
    end
    chk("stall_hold", steady, 1'b1);
    chk("stall_none", obs_q.size(), 0);
    ready_fix = 1'b1;
    settle("stall");
    apply(8'hFF, "stall_rel");

    // disable flushes held voices; edges while disabled produce nothing
    do_reset();
    apply(8'hBD, "hold16");
    @(negedge clk);
    enable = 1'b0;
    en_m = 1'b0;
    model_flush();
    settle("flush");
    apply(8'h00, "dis_break");
    apply(8'hFF, "dis_rel");
    enable = 1'b1;
    en_m = 1'b1;
    settle("reenable");

    // reset in the middle of an outstanding event
    do_reset();
    ready_fix = 1'b0;
    @(negedge clk);
    beam = 8'hFB;
    wait_valid("emit_valid");
    reset_n = 1'b0;
    #1;
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_busy", voice_busy, 4'h0);
    chk("rst_drop", drop_count, 8'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    obs_q.delete();
    exp_q.delete();
    ready_fix = 1'b1;
    model_change(8'hFB);
    settle("post_rst");
    apply(8'hFF, "post_rst_rel");

    // random beam patterns with random back-pressure
    rnd_ready = 1'b1;
    for (int r = 0; r < 20; r++) apply(8'($urandom), "rnd");
    apply(8'hFF, "rnd_end");
    rnd_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/harp_voice_scheduler.md
Name: harp_voice_scheduler

Overview:
- Turns the eight photodiode beam-break inputs into note-on/note-off events for the audio path.
- Synchronises and debounces each beam, then allocates one of NUM_VOICES synth voices per broken beam.
- Serialises events to the downstream synth/HPS event FIFO over a valid/ready handshake.
- Sits between the photodiode conduit pins and the audio generation logic in the FPGA fabric.

Parameters:
- NUM_STRINGS, 8, number of beams/photodiodes (index width SW = clog2 = 3).
- NUM_VOICES, 4, polyphony limit (index width VW = clog2 = 2).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (1 ms at 50 MHz).
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- beam_in  in  NUM_STRINGS  raw photodiode levels, asynchronous; 1 = beam intact, 0 = broken (plucked).
- enable  in  1  synchronous; 0 = play disabled.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_note_on  out  1  1 = note-on, 0 = note-off.
- evt_string  out  SW  string index of the event.
- evt_voice  out  VW  voice index of the event.
- voice_busy  out  NUM_VOICES  per-voice allocated flag.
- drop_count  out  8  saturating count of presses refused for lack of a voice.

Behaviour:
- Reset (async, reset_reset_n=0) clears or sets the following:
  - Sync flops and debounced state go to 1.
  - Pending flags, held tables, voice_busy, drop_count, round-robin pointer and evt_* outputs go to 0.
  - FSM goes to IDLE.
  - Reset asserted mid-EMIT drops the event; no partial handshake survives.
- Sync: two flops per beam; the debouncer sees only the second flop.
- Debounce, per string:
  - The counter runs while the synced level differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never toggles the stable level.
- Pending flags, per string:
  - A stable 1->0 transition sets press_pend; a stable 0->1 transition sets release_pend.
  - Release arriving while press_pend is set: clear both, no event.
  - Press arriving while release_pend is set: clear release_pend; the voice stays held, no event.
- Per-string tables: held[i] and voice_of[i].
- FSM states: IDLE, EMIT, FLUSH.
- IDLE with enable=1, selection:
  - Releases take priority: pick the first i with release_pend, scanning round-robin from rr_ptr.
  - Otherwise pick the first i with press_pend, scanning the same way.
- IDLE, release of a string with held[i]=1: load a note-off for voice_of[i], go to EMIT.
- IDLE, release of a string with held[i]=0 (press was dropped): clear the flag, no event, stay in IDLE.
- IDLE, press with a free voice: take the lowest-index free voice, load a note-on, go to EMIT.
- IDLE, press with no free voice: clear press_pend, leave held[i]=0, increment drop_count (saturates at 255), stay in IDLE.
- EMIT:
  - evt_valid=1 with all fields registered and stable until evt_ready=1.
  - On handshake the voice and held tables update, the pending flag clears, rr_ptr = (i+1) mod NUM_STRINGS, and the FSM returns to IDLE.
  - evt_valid falls in the cycle after the handshake.
- Throughput: at most one event per 2 cycles.
- Latency: stable-level toggle at cycle t -> pend flag at t+1 -> evt_valid at t+2, provided IDLE and enable=1.
- enable falls (any state, after any EMIT in progress completes its handshake): go to FLUSH.
  - FLUSH emits a note-off for each busy voice in ascending voice order, each with the full handshake.
  - It then clears all pending flags and held entries and returns to IDLE.
  - While enable=0, edges update the debounced levels but never set pending flags.
- voice_busy changes only on a handshake or on reset.

Decomposition:
- Shared package harp_pkg holds:
  - NUM_STRINGS and NUM_VOICES defaults, and the SW/VW widths.
  - State enum {IDLE, EMIT, FLUSH}.
  - Event struct {note_on, string, voice}.
- Sub-module beam_debouncer (2-flop sync plus counter, one bit wide) is instantiated NUM_STRINGS times.

Test Plan:
- Beam 3 held low for 60000 cycles, evt_ready=1 -> one note-on, string 3, voice 0; raise beam -> note-off, string 3, voice 0.
- Beam 5 toggled with 10000-cycle pulses -> no event; drop_count stays 0.
- Beams 0-4 broken in the same cycle -> note-ons for strings 0,1,2,3 on voices 0,1,2,3; string 4 dropped, drop_count=1; releasing beam 4 -> no event.
- evt_ready=0 for 20 cycles during a pending note-on -> evt_valid and fields held constant; exactly one event accepted when ready rises.
- Strings 1 and 6 held, then enable=0 -> note-offs on voices 0 then 1, voice_busy=0; new breaks while disabled -> no events.
- Assert reset_reset_n during EMIT -> evt_valid=0 immediately, voice_busy=0, drop_count=0; after release, normal operation resumes.
